lsu_store_buffer_unit: RTL and testbench

- Load/store functional unit. Sits directly downstream of the LSU reservation station and upstream of the common data bus, where it drives CDB slot 1 (valid bit 1, indices[7:4], new_values[31:16]).
- Accepts one issued memory op at a time and computes the effective address.
- Holds stores in an in-order store buffer until the ROB commits them, then drains them to data memory.
- Loads are served by store-to-load forwarding or by a single-port request/grant data memory interface.

---
 rtl/lsu_store_buffer_unit.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_lsu_store_buffer_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer_unit.sv
// ---------------------------------------------------------------------------
// lsu_store_buffer_unit
// Load/store functional unit between the LSU reservation station and CDB
// slot 1. Computes effective addresses, buffers stores in order until the ROB
// commits them, drains committed stores to a single-port data memory, and
// serves loads by store-to-load forwarding or a memory read.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_rob_idx/in_opcode  issued op from the reservation station
//   in_i/in_a_value/in_b_value     offset, base address, store data
//   lsu_full                       unit cannot accept an op this cycle
//   commit_valid/commit_rob_idx    four ROB commit lanes (4 bits per lane)
//   flush                          discard all speculative state
//   mem_req/we/addr/wdata, mem_gnt request/grant data memory port
//   mem_rvalid/mem_rdata           read return
//   cdb_valid/cdb_rob_idx/cdb_value result broadcast (registered)
// ---------------------------------------------------------------------------
module lsu_store_buffer_unit #(
    parameter int         SB_DEPTH = 4,
    parameter logic [3:0] OP_LD    = 4'hE,
    parameter logic [3:0] OP_ST    = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_rob_idx,
    input  logic [3:0]  in_opcode,
    input  logic [7:0]  in_i,
    input  logic [15:0] in_a_value,
    input  logic [15:0] in_b_value,
    output logic        lsu_full,
    input  logic [3:0]  commit_valid,
    input  logic [15:0] commit_rob_idx,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        cdb_valid,
    output logic [3:0]  cdb_rob_idx,
    output logic [15:0] cdb_value
);
    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LD_REQ     = 3'd1,
        S_LD_WAIT    = 3'd2,
        S_LD_DISCARD = 3'd3,
        S_ST_DRAIN   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_sb_addr [SB_DEPTH];
    logic [15:0]        r_sb_data [SB_DEPTH];
    logic [3:0]         r_sb_rob  [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_sb_cmt;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic [15:0]        r_ld_addr;
    logic [3:0]         r_ld_rob;
    logic               r_cdb_valid;
    logic [3:0]         r_cdb_rob;
    logic [15:0]        r_cdb_value;

    logic [15:0]        w_ea;
    logic               w_full;
    logic               w_accept;
    logic               w_is_ld;
    logic               w_is_st;
    logic               w_push;
    logic               w_pop;
    logic               w_drain_ok;
    logic               w_ld_miss;
    logic [SB_DEPTH-1:0] w_valid;
    logic [SB_DEPTH-1:0] w_match;
    logic [SB_DEPTH-1:0] w_cmt_next;
    logic               w_fwd_sel;
    logic               w_fwd_hit;
    logic [15:0]        w_fwd_data;
    logic               w_lead_run;
    logic [CW-1:0]      w_lead;
    logic               w_cdb_v;
    logic [3:0]         w_cdb_rob;
    logic [15:0]        w_cdb_val;

    assign w_ea       = in_a_value + {{8{in_i[7]}}, in_i};
    assign w_full     = (r_state != S_IDLE) || (r_count == DEPTH_C);
    assign lsu_full   = w_full;
    // A flush cycle ignores in_valid entirely.
    assign w_accept   = in_valid & ~w_full & ~flush;
    assign w_is_ld    = (in_opcode == OP_LD);
    assign w_is_st    = (in_opcode == OP_ST);
    assign w_push     = w_accept & w_is_st;
    assign w_pop      = (r_state == S_ST_DRAIN) & mem_gnt;
    // An accepted op has priority over starting a drain.
    assign w_drain_ok = ~w_accept & (r_count != {CW{1'b0}}) & r_sb_cmt[r_head];
    assign w_ld_miss  = w_accept & w_is_ld & ~w_fwd_hit;

    // Slot g is occupied when its distance from the head is below the count.
    genvar g;
    generate
        for (g = 0; g < SB_DEPTH; g++) begin : g_valid
            logic [PW-1:0] w_off;
            assign w_off      = PW'(g) - r_head;
            assign w_valid[g] = ({1'b0, w_off} < r_count);
        end
    endgenerate

    // Commit marking: any valid entry named by an active commit lane.
    always_comb begin
        w_match = '0;
        for (int j = 0; j < SB_DEPTH; j++) begin
            for (int l = 0; l < 4; l++) begin
                w_match[j] = w_match[j] |
                    (commit_valid[l] & (commit_rob_idx[4*l +: 4] == r_sb_rob[j]));
            end
        end
        w_cmt_next = w_valid & (r_sb_cmt | w_match);
    end

    // Walk entries oldest to youngest: the last address match is the
    // youngest store, and the run of committed entries from the head is
    // what survives a flush.
    always_comb begin
        w_fwd_sel  = 1'b0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = 16'h0000;
        w_lead_run = 1'b1;
        w_lead     = {CW{1'b0}};
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_fwd_sel  = (CW'(k) < r_count) && (r_sb_addr[r_head + PW'(k)] == w_ea);
            w_fwd_hit  = w_fwd_hit | w_fwd_sel;
            w_fwd_data = w_fwd_sel ? r_sb_data[r_head + PW'(k)] : w_fwd_data;
            w_lead_run = w_lead_run & w_cmt_next[r_head + PW'(k)];
            w_lead     = w_lead + CW'(w_lead_run);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ld_miss) begin
                    w_state_nxt = S_LD_REQ;
                end else if (w_drain_ok) begin
                    w_state_nxt = S_ST_DRAIN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LD_REQ: begin
                if (flush) begin
                    w_state_nxt = mem_gnt ? S_LD_DISCARD : S_IDLE;
                end else begin
                    w_state_nxt = mem_gnt ? S_LD_WAIT : S_LD_REQ;
                end
            end
            S_LD_WAIT: begin
                // Data arriving in the flush cycle is simply dropped; no need
                // to wait for a second return.
                if (mem_rvalid) begin
                    w_state_nxt = S_IDLE;
                end else if (flush) begin
                    w_state_nxt = S_LD_DISCARD;
                end else begin
                    w_state_nxt = S_LD_WAIT;
                end
            end
            S_LD_DISCARD: w_state_nxt = mem_rvalid ? S_IDLE : S_LD_DISCARD;
            S_ST_DRAIN:   w_state_nxt = mem_gnt ? S_IDLE : S_ST_DRAIN;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: memory port driven from registered state only.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        case (r_state)
            S_LD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_ld_addr;
            end
            S_ST_DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_sb_addr[r_head];
                mem_wdata = r_sb_data[r_head];
            end
            default: mem_req = 1'b0;
        endcase
    end

    // Next CDB broadcast: immediate ops or returned load data.
    always_comb begin
        w_cdb_v   = 1'b0;
        w_cdb_rob = 4'h0;
        w_cdb_val = 16'h0000;
        if (w_accept && !w_ld_miss) begin
            w_cdb_v   = 1'b1;
            w_cdb_rob = in_rob_idx;
            w_cdb_val = w_is_ld ? w_fwd_data : 16'h0000;
        end else if ((r_state == S_LD_WAIT) && mem_rvalid && !flush) begin
            w_cdb_v   = 1'b1;
            w_cdb_rob = r_ld_rob;
            w_cdb_val = mem_rdata;
        end else begin
            w_cdb_v   = 1'b0;
        end
    end

    // CDB output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_rob   <= 4'h0;
            r_cdb_value <= 16'h0000;
        end else begin
            r_cdb_valid <= w_cdb_v;
            r_cdb_rob   <= w_cdb_rob;
            r_cdb_value <= w_cdb_val;
        end
    end

    assign cdb_valid   = r_cdb_valid;
    assign cdb_rob_idx = r_cdb_rob;
    assign cdb_value   = r_cdb_value;

    // Latch address and ROB index of a load that must go to memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_addr <= 16'h0000;
            r_ld_rob  <= 4'h0;
        end else if (w_ld_miss) begin
            r_ld_addr <= w_ea;
            r_ld_rob  <= in_rob_idx;
        end
    end

    // Buffer pointers; a flush truncates to the committed run from the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (flush) begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_head + w_lead[PW-1:0];
            r_count <= w_lead - CW'(w_pop);
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_push);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Buffer storage and committed flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_cmt <= '0;
            for (int j = 0; j < SB_DEPTH; j++) begin
                r_sb_addr[j] <= 16'h0000;
                r_sb_data[j] <= 16'h0000;
                r_sb_rob[j]  <= 4'h0;
            end
        end else begin
            r_sb_cmt <= w_cmt_next;
            if (w_push) begin
                r_sb_addr[r_tail] <= w_ea;
                r_sb_data[r_tail] <= in_b_value;
                r_sb_rob[r_tail]  <= in_rob_idx;
                r_sb_cmt[r_tail]  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lsu_store_buffer_unit.sv
// Randomized bench for lsu_store_buffer_unit with a transaction-level model:
// an in-order queue of buffered stores, a sparse data memory, and one
// outstanding-load record. Inputs are driven and outputs sampled on negedge.
module tb_lsu_store_buffer_unit;
    localparam int         SB_DEPTH = 4;
    localparam logic [3:0] OP_LD    = 4'hE;
    localparam logic [3:0] OP_ST    = 4'hF;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_rob_idx;
    logic [3:0]  in_opcode;
    logic [7:0]  in_i;
    logic [15:0] in_a_value;
    logic [15:0] in_b_value;
    logic        lsu_full;
    logic [3:0]  commit_valid;
    logic [15:0] commit_rob_idx;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_idx;
    logic [15:0] cdb_value;

    lsu_store_buffer_unit #(.SB_DEPTH(SB_DEPTH), .OP_LD(OP_LD), .OP_ST(OP_ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_rob_idx(in_rob_idx), .in_opcode(in_opcode),
        .in_i(in_i), .in_a_value(in_a_value), .in_b_value(in_b_value),
        .lsu_full(lsu_full),
        .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  rob;
        bit          cmt;
    } sb_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         sbq[$];
    logic [15:0] mem_model [logic [15:0]];
    bit          ld_active, ld_granted, ld_disc;
    logic [3:0]  ld_rob;
    logic [15:0] ld_addr, ld_val;
    int          rv_cnt;
    bit          exp_v;
    logic [3:0]  exp_rob;
    logic [15:0] exp_val;
    logic [3:0]  next_rob;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 16'h5A5A;
    endfunction

    function automatic bit rob_used(input logic [3:0] r);
        foreach (sbq[j]) if (sbq[j].rob == r) return 1'b1;
        if (ld_active && ld_rob == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0; in_rob_idx = 4'h0; in_opcode = 4'h0; in_i = 8'h00;
        in_a_value = 16'h0000; in_b_value = 16'h0000;
        commit_valid = 4'h0; commit_rob_idx = 16'h0000; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    endtask

    // One cycle: check outputs at this negedge, then drive the next inputs.
    task automatic run_cycle(input bit allow_ops, input bit force_commit);
        bit          exp_full, flush_now, have, acc, hit;
        int          u;
        int          lane;
        logic [15:0] ea, fwd;
        logic [3:0]  rob;

        check_eq("cdb_valid", cdb_valid, exp_v);
        if (exp_v) begin
            check_eq("cdb_rob", cdb_rob_idx, exp_rob);
            check_eq("cdb_value", cdb_value, exp_val);
        end
        exp_v = 1'b0;
        exp_full = ld_active || (sbq.size() == SB_DEPTH) || (mem_req && mem_we);
        check_eq("lsu_full", lsu_full, exp_full);

        flush_now = allow_ops && ($urandom_range(0, 99) < 4);
        flush = flush_now;

        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0000;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_read(ld_addr);
                if (!ld_disc && !flush_now) begin
                    exp_v = 1'b1; exp_rob = ld_rob; exp_val = ld_val;
                end
                ld_active = 1'b0;
            end
        end
        if (mem_req) begin
            if (mem_we) begin
                have = (sbq.size() != 0);
                check_eq("drain_nonempty", have, 1'b1);
                if (have) begin
                    check_eq("drain_committed", sbq[0].cmt, 1'b1);
                    check_eq("drain_addr", mem_addr, sbq[0].addr);
                    check_eq("drain_wdata", mem_wdata, sbq[0].data);
                    if ($urandom_range(0, 1) == 1) begin
                        mem_gnt = 1'b1;
                        mem_model[sbq[0].addr] = sbq[0].data;
                        void'(sbq.pop_front());
                    end
                end
            end else begin
                check_eq("rd_expected", ld_active && !ld_granted, 1'b1);
                if (ld_active && !ld_granted) begin
                    check_eq("rd_addr", mem_addr, ld_addr);
                    if ($urandom_range(0, 2) == 0) begin
                        mem_gnt    = 1'b1;
                        ld_granted = 1'b1;
                        rv_cnt     = $urandom_range(1, 4);
                    end
                end
            end
        end

        if (flush_now) begin
            if (ld_active) begin
                if (!ld_granted) ld_active = 1'b0;
                else ld_disc = 1'b1;
            end
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (!sbq[j].cmt) sbq.delete(j);
            end
        end

        // Commit in program order, oldest uncommitted store first.
        commit_valid   = 4'h0;
        commit_rob_idx = 16'($urandom);
        if (!flush_now && (force_commit || $urandom_range(0, 99) < 30)) begin
            u = -1;
            foreach (sbq[j]) if (u < 0 && !sbq[j].cmt) u = j;
            if (u >= 0) begin
                lane = $urandom_range(0, 3);
                commit_valid[lane] = 1'b1;
                commit_rob_idx[4*lane +: 4] = sbq[u].rob;
                sbq[u].cmt = 1'b1;
                if (u + 1 < sbq.size() && $urandom_range(0, 1) == 1) begin
                    lane = (lane + 1) % 4;
                    commit_valid[lane] = 1'b1;
                    commit_rob_idx[4*lane +: 4] = sbq[u+1].rob;
                    sbq[u+1].cmt = 1'b1;
                end
            end
        end

        in_valid = allow_ops && ($urandom_range(0, 99) < 60);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: in_opcode = OP_LD;
            4, 5, 6, 7: in_opcode = OP_ST;
            default:    in_opcode = 4'($urandom_range(0, 13));
        endcase
        case ($urandom_range(0, 2))
            0:       in_a_value = 16'h0100 + 16'($urandom_range(0, 3));
            1:       in_a_value = 16'hFFFC + 16'($urandom_range(0, 3));
            default: in_a_value = 16'($urandom_range(0, 3));
        endcase
        in_i       = 8'($urandom_range(0, 15) + 248);
        in_b_value = 16'($urandom);
        rob = next_rob;
        while (rob_used(rob)) rob = rob + 4'h1;
        in_rob_idx = rob;
        acc = in_valid && !exp_full && !flush_now;
        if (acc) begin
            next_rob = rob + 4'h1;
            ea = 16'((int'(in_a_value) + int'($signed(in_i))) & 32'hFFFF);
            if (in_opcode == OP_ST) begin
                sbq.push_back('{addr: ea, data: in_b_value, rob: rob, cmt: 1'b0});
                exp_v = 1'b1; exp_rob = rob; exp_val = 16'h0000;
            end else if (in_opcode == OP_LD) begin
                hit = 1'b0; fwd = 16'h0000;
                foreach (sbq[j]) if (sbq[j].addr == ea) begin hit = 1'b1; fwd = sbq[j].data; end
                if (hit) begin
                    exp_v = 1'b1; exp_rob = rob; exp_val = fwd;
                end else begin
                    ld_active = 1'b1; ld_granted = 1'b0; ld_disc = 1'b0;
                    ld_rob = rob; ld_addr = ea; ld_val = mem_read(ea);
                end
            end else begin
                exp_v = 1'b1; exp_rob = rob; exp_val = 16'h0000;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain_all(input string tag);
        for (int c = 0; c < 400 && (sbq.size() != 0 || ld_active); c++) run_cycle(1'b0, 1'b1);
        run_cycle(1'b0, 1'b1);
        check_eq(tag, (sbq.size() == 0) && !ld_active, 1'b1);
    endtask

    initial begin
        bit got;
        drive_idle();
        rst_n = 1'b0; ld_active = 1'b0; ld_granted = 1'b0; ld_disc = 1'b0;
        rv_cnt = 0; exp_v = 1'b0; next_rob = 4'h0;
        ld_rob = 4'h0; ld_addr = 16'h0000; ld_val = 16'h0000;
        exp_rob = 4'h0; exp_val = 16'h0000;
        #2;
        check_eq("rst_cdb_valid", cdb_valid, 1'b0);
        check_eq("rst_cdb_value", cdb_value, 16'h0000);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 16'h0000);
        check_eq("rst_lsu_full", lsu_full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3000) run_cycle(1'b1, 1'b0);
        drain_all("drain_end1");

        // Reset while a drain is in progress.
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            if (mem_req && mem_we) begin
                got = 1'b1;
                rst_n = 1'b0;
                #1;
                check_eq("rstmid_mem_req", mem_req, 1'b0);
                check_eq("rstmid_cdb_valid", cdb_valid, 1'b0);
                check_eq("rstmid_lsu_full", lsu_full, 1'b0);
                sbq.delete();
                ld_active = 1'b0; ld_disc = 1'b0; rv_cnt = 0; exp_v = 1'b0;
                drive_idle();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                run_cycle(1'b1, 1'b1);
            end
        end
        check_eq("rstmid_reached", got, 1'b1);

        repeat (800) run_cycle(1'b1, 1'b0);
        drain_all("drain_end2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
